// File: rtl/ifacc_pkg.sv
// Shared types and sizing for the IfEnt result accumulator.
// The batch record is sized from the package constants, so a different WIDTH/COUNT is set here.
package ifacc_pkg;

    function automatic int sumWidth(input int w, input int c);
        return w + $clog2(c);
    endfunction

    function automatic int cntWidth(input int c);
        return $clog2(c + 1);
    endfunction

    localparam int IFACC_WIDTH = 8;
    localparam int IFACC_COUNT = 4;
    localparam int IFACC_SW    = sumWidth(IFACC_WIDTH, IFACC_COUNT);
    localparam int IFACC_CW    = cntWidth(IFACC_COUNT);

    localparam logic [IFACC_WIDTH-1:0] MIN_INIT = '1;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [IFACC_SW-1:0]    sum;
        logic [IFACC_WIDTH-1:0] min;
        logic [IFACC_WIDTH-1:0] max;
        logic [IFACC_CW-1:0]    count;
    } batch_t;

    localparam batch_t BATCH_CLEAR = '{sum: '0, min: MIN_INIT, max: '0, count: '0};

endpackage

// File: rtl/if_stat_update.sv
// Folds one unsigned sample into a running batch record (sum, min, max, count).
module if_stat_update
    import ifacc_pkg::*;
(
    input  batch_t                 i_cur,
    input  logic [IFACC_WIDTH-1:0] i_sample,
    output batch_t                 o_next
);

    always_comb begin
        o_next       = i_cur;
        o_next.sum   = i_cur.sum + IFACC_SW'(i_sample);
        o_next.min   = (i_sample < i_cur.min) ? i_sample : i_cur.min;
        o_next.max   = (i_sample > i_cur.max) ? i_sample : i_cur.max;
        o_next.count = i_cur.count + IFACC_CW'(1);
    end

endmodule

// File: rtl/if_result_accum.sv
// Collects IfEnt result samples into batches and presents sum/min/max/count
// over a valid/ready handshake; FLUSH forces out a partial batch.
module if_result_accum
    import ifacc_pkg::*;
#(
    parameter int WIDTH = IFACC_WIDTH,
    parameter int COUNT = IFACC_COUNT,
    parameter int CW    = $clog2(COUNT + 1),
    parameter int SW    = WIDTH + $clog2(COUNT)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             FLUSH,
    output logic [SW-1:0]    OUT_SUM,
    output logic [WIDTH-1:0] OUT_MIN,
    output logic [WIDTH-1:0] OUT_MAX,
    output logic [CW-1:0]    OUT_COUNT,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam logic [CW-1:0] FULL_CNT = CW'(COUNT);

    state_t r_state;
    batch_t r_acc;
    batch_t r_out;

    batch_t w_next;
    batch_t w_upd;
    logic   w_accept;
    logic   w_full;
    logic   w_flush;
    logic   w_emit;

    if_stat_update u_stat (
        .i_cur    (r_acc),
        .i_sample (IN_DATA),
        .o_next   (w_next)
    );

    assign IN_READY = (r_state == ACCUM);
    assign w_accept = IN_VALID && IN_READY;
    assign w_upd    = w_accept ? w_next : r_acc;
    assign w_full   = w_accept && (w_next.count == FULL_CNT);
    // A flush only emits when the batch, including a same-cycle sample, is non-empty.
    assign w_flush  = FLUSH && (w_upd.count != '0);
    assign w_emit   = w_full || w_flush;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ACCUM;
            r_acc   <= BATCH_CLEAR;
            r_out   <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    r_acc <= w_upd;
                    if (w_emit) begin
                        r_out   <= w_upd;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (OUT_READY) begin
                        r_acc   <= BATCH_CLEAR;
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign OUT_VALID = (r_state == HOLD);
    assign OUT_SUM   = r_out.sum;
    assign OUT_MIN   = r_out.min;
    assign OUT_MAX   = r_out.max;
    assign OUT_COUNT = r_out.count;

endmodule

// File: doc/if_result_accum.md
Name: if_result_accum

Overview:
- Downstream consumer of the IfEnt 8-bit result (XOUT). It collects a batch of COUNT result samples and reports their sum, minimum and maximum over a valid/ready output handshake.
- Sits between the IfEnt stage, whose result is registered by the feeder into IN_DATA/IN_VALID, and the statistics/readout logic.
- A FLUSH input forces out a partial batch.

Parameters:
- WIDTH, 8, sample width (matches XOUT).
- COUNT, 4, samples per full batch; legal range 2..256.
- CW, $clog2(COUNT+1), width of the sample counter and OUT_COUNT.
- SW, WIDTH+$clog2(COUNT), sum width; cannot overflow.

Ports:
- CLK  input  1  clock, all logic on the rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- IN_DATA  input  WIDTH  result sample (unsigned).
- IN_VALID  input  1  sample present.
- IN_READY  output  1  block can accept a sample.
- FLUSH  input  1  one-cycle request to emit the partial batch.
- OUT_SUM  output  SW  unsigned sum of the batch.
- OUT_MIN  output  WIDTH  minimum sample of the batch.
- OUT_MAX  output  WIDTH  maximum sample of the batch.
- OUT_COUNT  output  CW  number of samples in the batch (1..COUNT).
- OUT_VALID  output  1  batch result present.
- OUT_READY  input  1  consumer accepts the result.

Behaviour:
- Interface: one clock, CLK. Reset is synchronous and active-low on RST_N. All state updates only on the rising edge of CLK.
- Reset (RST_N=0 at an edge): state=ACCUM. Accumulator cleared: sum=0, min=all-ones, max=0, cnt=0.
- Reset values of outputs: OUT_VALID=0, OUT_SUM=0, OUT_MIN=0, OUT_MAX=0, OUT_COUNT=0, IN_READY=1.
- Reset mid-batch or mid-HOLD discards all data; no result is emitted.
- States: ACCUM, HOLD.
- IN_READY = (state==ACCUM), combinational from state only.
- ACCUM, on an accept (IN_VALID & IN_READY):
  - sum += IN_DATA, zero-extended to SW.
  - min = (IN_DATA < min) ? IN_DATA : min.
  - max = (IN_DATA > max) ? IN_DATA : max.
  - cnt += 1.
- ACCUM → HOLD, batch complete: on the accept that makes cnt reach COUNT.
  - Output registers load the updated values in that same edge.
  - OUT_VALID=1 from the next cycle; latency of 1 cycle after the COUNTth accept.
- ACCUM → HOLD, flush:
  - Case 1: FLUSH=1 and cnt>0. Emit the partial batch.
  - Case 2: FLUSH=1 and a sample is accepted in the same cycle. The sample is included first, then the batch is emitted.
  - Case 3: FLUSH=1 with cnt=0 and no accept. Ignored; stay in ACCUM.
- HOLD:
  - Outputs stable; OUT_VALID=1; IN_READY=0; FLUSH ignored.
  - On OUT_READY=1: OUT_VALID→0 next cycle, accumulator cleared, return to ACCUM.
  - The output data registers keep their last values after the handshake (don't-care while OUT_VALID=0).
- No sample is accepted in the handshake cycle. The minimum period of a full batch is COUNT+1 cycles.
- OUT_VALID must never drop before OUT_READY. Output data must not change while OUT_VALID=1.
- Arithmetic is unsigned throughout. Min/max comparisons are WIDTH-bit unsigned.

Decomposition:
- Shared package ifacc_pkg:
  - typedef state_t enum {ACCUM, HOLD}.
  - typedef struct batch_t {sum, min, max, count}, with widths derived from WIDTH/COUNT via package functions.
  - Constant MIN_INIT = all-ones.
- One natural sub-module: if_stat_update, purely combinational. It takes the current batch_t and a sample and returns the updated batch_t. The top holds the FSM, counter and registers.

Test Plan:
- Reset then 4 accepts of 10,200,3,50 (COUNT=4) -> one cycle after the 4th accept: OUT_VALID=1, OUT_SUM=263, OUT_MIN=3, OUT_MAX=200, OUT_COUNT=4; IN_READY=0 until the OUT_READY handshake.
- OUT_READY held low 5 cycles, then pulsed -> outputs unchanged for all 5 cycles; OUT_VALID=0 and IN_READY=1 the cycle after the pulse; the next batch starts from sum=0.
- Overflow bound, 4×255 -> OUT_SUM=1020 (10 bits), OUT_MIN=OUT_MAX=255.
- Flush cases:
  - Accepts 7,9, then FLUSH alone -> OUT_COUNT=2, OUT_SUM=16, OUT_MIN=7, OUT_MAX=9.
  - FLUSH together with an accept of 1 after the single sample 5 -> OUT_COUNT=2, OUT_SUM=6, OUT_MIN=1.
  - FLUSH with an empty batch -> no OUT_VALID, state stays ACCUM.
- IN_VALID asserted during HOLD with value 99 -> not accepted (IN_READY=0), so it is not counted; the value is accepted only once back in ACCUM.
- RST_N=0 for one cycle after 3 of 4 samples, then 4 fresh samples of 1 -> OUT_SUM=4, OUT_COUNT=4; no stale data; all outputs read 0 while in reset.
